// File: rtl/rf_pkg.sv
// Shared widths, read-port request type and parity helper for the register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W  = 32;
  localparam int unsigned RF_ADDR_W  = 5;
  localparam int unsigned RF_PAR_MAX = 64;

  // Address field is RF_ADDR_W wide; ADDR_W above RF_ADDR_W is not supported.
  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
  } rd_req_t;

  // Even parity: stored bit makes the total count of ones even.
  function automatic logic rf_parity(input logic [RF_PAR_MAX-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, write-back clears, issue wins a tie.
module rf_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [DEPTH-1:0]  busy_next
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  always_comb begin
    set_vec = iss_en ? (DEPTH'(1) << iss_addr) : '0;
    clr_vec = wr_en  ? (DEPTH'(1) << wr_addr)  : '0;
    if (ZERO_REG) set_vec[0] = 1'b0;
    busy_next = set_vec | (busy_q & ~clr_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with registered write-first reads and busy scoreboard.
// Optional storage parity and sticky parity_err when RF_PARITY_EN is defined.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_rdy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [DEPTH-1:0]         busy_vec
`ifdef RF_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_next;
  logic                     wr_ok;
  rd_req_t                  req [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] data_d;
  logic [NUM_RD-1:0]        rdy_d;
  logic [ADDR_W-1:0]        ra;
  logic                     zero_hit;
  logic                     byp_hit;
`ifdef RF_PARITY_EN
  logic [DEPTH-1:0]         par_q;
  logic                     par_hit;
`endif

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy_vec  (busy_vec),
    .busy_next (busy_next)
  );

  assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      req[p].en   = rd_en[p];
      req[p].addr = RF_ADDR_W'(rd_addr[p*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    data_d   = rd_data;
    rdy_d    = rd_rdy;
    ra       = '0;
    zero_hit = 1'b0;
    byp_hit  = 1'b0;
`ifdef RF_PARITY_EN
    par_hit  = 1'b0;
`endif
    for (int p = 0; p < NUM_RD; p++) begin
      ra       = ADDR_W'(req[p].addr);
      zero_hit = ZERO_REG && (ra == '0);
      byp_hit  = wr_en && (wr_addr == ra);
      if (req[p].en) begin
        if (zero_hit)     data_d[p*DATA_W +: DATA_W] = '0;
        else if (byp_hit) data_d[p*DATA_W +: DATA_W] = wr_data;
        else              data_d[p*DATA_W +: DATA_W] = mem_q[ra];
        // Readiness reflects the scoreboard after this edge's issue/write-back.
        rdy_d[p] = zero_hit || !busy_next[ra];
`ifdef RF_PARITY_EN
        if (!zero_hit && !byp_hit &&
            (rf_parity(RF_PAR_MAX'(mem_q[ra])) != par_q[ra])) begin
          par_hit = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_rdy  <= '1;
    end else begin
      rd_data <= data_d;
      rd_rdy  <= rdy_d;
    end
  end

`ifdef RF_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q      <= '0;
      parity_err <= 1'b0;
    end else begin
      if (wr_ok) par_q[wr_addr] <= rf_parity(RF_PAR_MAX'(wr_data));
      parity_err <= parity_err | par_hit;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// against an array/bitmask reference model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_rdy;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [31:0] busy_vec;
`ifdef RF_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic [31:0] m_data [2];
  logic [1:0]  m_rdy;

  reg_file_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .ZERO_REG (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_rdy   (rd_rdy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
`ifdef RF_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy    = '0;
    m_data[0] = '0;
    m_data[1] = '0;
    m_rdy     = 2'b11;
  endtask

  // Applies one cycle of stimulus, advances the model, returns at posedge+1.
  task automatic do_cycle(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ie, input logic [4:0] ia);
    logic [31:0] nb;
    logic [4:0]  ra [2];
    rd_en    = re;
    rd_addr  = {a1, a0};
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ia;
    ra[0] = a0;
    ra[1] = a1;
    nb = m_busy;
    if (we) nb[wa] = 1'b0;
    if (ie && ia != 5'd0) nb[ia] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (re[p]) begin
        if (ra[p] == 5'd0) begin
          m_data[p] = '0;
          m_rdy[p]  = 1'b1;
        end else begin
          m_data[p] = (we && wa == ra[p]) ? wd : m_mem[ra[p]];
          m_rdy[p]  = !nb[ra[p]];
        end
      end
    end
    if (we && wa != 5'd0) m_mem[wa] = wd;
    m_busy = nb;
    @(posedge clk);
    #1;
    rd_en  = '0;
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++;
      $display("FAIL reset_busy got %h exp %h", busy_vec, 32'h0); end
    checks++; if (rd_data !== 64'h0) begin errors++;
      $display("FAIL reset_data got %h exp %h", rd_data, 64'h0); end
    checks++; if (rd_rdy !== 2'b11) begin errors++;
      $display("FAIL reset_rdy got %b exp %b", rd_rdy, 2'b11); end
    rst_n = 1'b1;
    do_cycle(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (rd_data !== 64'h0 || rd_rdy !== 2'b11) begin errors++;
      $display("FAIL read5_after_reset got %h/%b exp 0/11", rd_data, rd_rdy); end
  endtask

  task automatic test_bypass();
    do_cycle(2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_rdy[0] !== 1'b1) begin errors++;
      $display("FAIL bypass7 got %h/%b exp deadbeef/1", rd_data[31:0], rd_rdy[0]); end
    do_cycle(2'b10, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL stored7 got %h exp deadbeef", rd_data[63:32]); end
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL hold_port0 got %h exp deadbeef", rd_data[31:0]); end
  endtask

  task automatic test_zero_reg();
    do_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    do_cycle(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (rd_data !== 64'h0 || rd_rdy !== 2'b11) begin errors++;
      $display("FAIL zero_read got %h/%b exp 0/11", rd_data, rd_rdy); end
    do_cycle(2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 32'h5678, 1'b1, 5'd0);
    checks++; if (rd_data[31:0] !== 32'h0 || rd_rdy[0] !== 1'b1) begin errors++;
      $display("FAIL zero_bypass got %h/%b exp 0/1", rd_data[31:0], rd_rdy[0]); end
    checks++; if (busy_vec !== 32'h0) begin errors++;
      $display("FAIL zero_busy got %h exp 0", busy_vec); end
  endtask

  task automatic test_scoreboard();
    do_cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    do_cycle(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (rd_rdy[0] !== 1'b0 || busy_vec[3] !== 1'b1) begin errors++;
      $display("FAIL pending3 got rdy %b busy %b exp 0/1", rd_rdy[0], busy_vec[3]); end
    do_cycle(2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0);
    checks++; if (rd_rdy[0] !== 1'b1 || rd_data[31:0] !== 32'hA5) begin errors++;
      $display("FAIL wb3 got %b/%h exp 1/a5", rd_rdy[0], rd_data[31:0]); end
    checks++; if (busy_vec[3] !== 1'b0) begin errors++;
      $display("FAIL clr3 got %b exp 0", busy_vec[3]); end
  endtask

  task automatic test_iss_wb_same();
    do_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++;
      $display("FAIL iss_wb9 got %h exp 00000200", busy_vec); end
    do_cycle(2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (rd_rdy[1] !== 1'b0 || rd_data[63:32] !== 32'h99) begin errors++;
      $display("FAIL read9 got %b/%h exp 0/99", rd_rdy[1], rd_data[63:32]); end
  endtask

  task automatic test_async_reset();
    do_cycle(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    checks++; if (busy_vec !== 32'h0000_0208 || rd_data !== 64'hDEADBEEF_DEADBEEF) begin
      errors++;
      $display("FAIL pre_reset got %h/%h exp 00000208/deadbeefdeadbeef", busy_vec, rd_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_vec !== 32'h0 || rd_data !== 64'h0 || rd_rdy !== 2'b11) begin
      errors++;
      $display("FAIL async_reset got %h/%h/%b exp 0/0/11", busy_vec, rd_data, rd_rdy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_cycle(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (rd_data[31:0] !== 32'h0 || rd_rdy[0] !== 1'b1) begin errors++;
      $display("FAIL mem_cleared got %h/%b exp 0/1", rd_data[31:0], rd_rdy[0]); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      do_cycle(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
      checks++;
      if (rd_data !== {m_data[1], m_data[0]} || rd_rdy !== m_rdy || busy_vec !== m_busy)
      begin
        errors++;
        if (bad < 10)
          $display("FAIL random cyc %0d got %h/%b/%h exp %h/%b/%h", n, rd_data, rd_rdy,
                   busy_vec, {m_data[1], m_data[0]}, m_rdy, m_busy);
        bad++;
      end
    end
  endtask

`ifdef RF_PARITY_EN
  task automatic test_parity();
    logic [31:0] pv;
    do_cycle(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 32'h55, 1'b0, 5'd0);
    checks++; if (parity_err !== 1'b0) begin errors++;
      $display("FAIL parity_clean got %b exp 0", parity_err); end
    pv = dut.par_q;
    force dut.par_q = pv ^ 32'h10;
    do_cycle(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    release dut.par_q;
    do_cycle(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checks++; if (parity_err !== 1'b1) begin errors++;
      $display("FAIL parity_sticky got %b exp 1", parity_err); end
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_iss_wb_same();
        test_async_reset();
        test_random();
`ifdef RF_PARITY_EN
        test_parity();
`endif
      end
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout got running exp done");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
